// File: rtl/sandbox_link_pkg.sv
// Shared frame constants and FSM encodings for the sandbox host link.
package sandbox_link_pkg;

  localparam int FRAME_BYTES = 5;
  localparam int IDX_W       = 3;

  typedef logic [IDX_W-1:0] idx_t;

  // Index of the final byte of a frame (control/status byte is index 0).
  localparam idx_t LAST_IDX = idx_t'(FRAME_BYTES - 1);

  localparam logic [1:0] RX_COLLECT = 2'd0;
  localparam logic [1:0] RX_PRESENT = 2'd1;
  localparam logic [1:0] RX_DRAIN   = 2'd2;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_SEND = 2'd1;
  localparam logic [1:0] TX_DONE = 2'd2;

endpackage

// File: rtl/sandbox_link_tx_serializer.sv
// Captures {status, data} on a start request and sends it MSB-byte first
// over a valid/ready byte handshake, one frame per start assertion.
module sandbox_link_tx_serializer
  import sandbox_link_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  status,
  input  logic [31:0] data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_byte
);

  logic [1:0]  state;
  logic [39:0] shift;
  idx_t        idx;

  // The top byte of the shift register is the byte on offer; it only moves on a transfer.
  assign tx_byte = shift[39:32];

  // TX state machine: capture, shift out on each accepted byte, then wait for start to drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TX_IDLE;
      shift    <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (start) begin
            shift    <= {status, data};
            idx      <= '0;
            tx_valid <= 1'b1;
            state    <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_ready) begin
            if (idx == LAST_IDX) begin
              tx_valid <= 1'b0;
              state    <= TX_DONE;
            end else begin
              shift <= {shift[31:0], 8'h00};
              idx   <= idx + idx_t'(1);
            end
          end
        end
        TX_DONE: begin
          // Level-sensitive re-arm: a held request never produces a second frame.
          if (!start) state <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sandbox_host_link.sv
// Host-side end of the sandbox handshake: assembles 5-byte command frames,
// presents them to the process, and serializes 5-byte response frames.
module sandbox_host_link
  import sandbox_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        rxValid,
  input  logic [7:0]  rxByte,
  output logic        rxReady,
  output logic        txValid,
  output logic [7:0]  txByte,
  input  logic        txReady,
  output logic        dataReceived,
  output logic [7:0]  control,
  output logic [31:0] inputData,
  input  logic        clearDR,
  input  logic        transmitData,
  input  logic [7:0]  status,
  input  logic [31:0] outputData,
  output logic        frameError
);

  localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       rx_state;
  idx_t             rx_count;
  logic [CNT_W-1:0] idle_cnt;
  logic [7:0]       rx_ctrl;
  logic [23:0]      rx_shift;
  logic             rx_xfer;

  // Bytes are only accepted while collecting; held low during reset so nothing is consumed.
  assign rxReady = (rx_state == RX_COLLECT) && !reset;
  assign rx_xfer = rxValid && rxReady;

  // RX assembly, inter-byte timeout and dataReceived/clearDR handshake.
  always_ff @(posedge masterClock) begin
    if (reset) begin
      rx_state     <= RX_COLLECT;
      rx_count     <= '0;
      idle_cnt     <= '0;
      rx_ctrl      <= '0;
      rx_shift     <= '0;
      control      <= '0;
      inputData    <= '0;
      dataReceived <= 1'b0;
      frameError   <= 1'b0;
    end else begin
      frameError <= 1'b0;
      case (rx_state)
        RX_COLLECT: begin
          if (rx_xfer) begin
            // A transfer always clears the idle counter, so it beats a coincident timeout.
            idle_cnt <= '0;
            if (rx_count == LAST_IDX) begin
              control      <= rx_ctrl;
              inputData    <= {rx_shift, rxByte};
              dataReceived <= 1'b1;
              rx_count     <= '0;
              rx_state     <= RX_PRESENT;
            end else begin
              if (rx_count == '0) rx_ctrl <= rxByte;
              else                rx_shift <= {rx_shift[15:0], rxByte};
              rx_count <= rx_count + idx_t'(1);
            end
          end else if (TIMEOUT_EN && (rx_count != '0)) begin
            if (idle_cnt == IDLE_LAST) begin
              rx_count   <= '0;
              idle_cnt   <= '0;
              frameError <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + CNT_W'(1);
            end
          end
        end
        RX_PRESENT: begin
          if (clearDR) begin
            dataReceived <= 1'b0;
            rx_state     <= RX_DRAIN;
          end
        end
        RX_DRAIN: begin
          // Wait for the process to drop clearDR so one clear never releases two frames.
          if (!clearDR) begin
            rx_count <= '0;
            rx_state <= RX_COLLECT;
          end
        end
        default: rx_state <= RX_COLLECT;
      endcase
    end
  end

  sandbox_link_tx_serializer u_tx (
    .clk      (masterClock),
    .reset    (reset),
    .start    (transmitData),
    .status   (status),
    .data     (outputData),
    .tx_ready (txReady),
    .tx_valid (txValid),
    .tx_byte  (txByte)
  );

endmodule
